// File: rtl/prog_loader_pkg.sv
// Shared constants for the byte-serial instruction-memory loader.
package prog_loader_pkg;

   localparam int unsigned LEN_W  = 8;
   localparam int unsigned WORD_W = 16;

   localparam logic [LEN_W-1:0] SYNC_BYTE = 8'hA5;

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_GETLEN = 3'd1;
   localparam logic [2:0] S_GETHI  = 3'd2;
   localparam logic [2:0] S_GETLO  = 3'd3;
   localparam logic [2:0] S_WRITE  = 3'd4;
   localparam logic [2:0] S_GETCHK = 3'd5;
   localparam logic [2:0] S_DONE   = 3'd6;
   localparam logic [2:0] S_ERR    = 3'd7;

endpackage

// File: rtl/prog_loader.sv
// Loads framed big-endian words into instruction memory from address 0 and
// releases the core from reset only after a frame arrives with a good checksum.
module prog_loader
   import prog_loader_pkg::*;
#(
   parameter int unsigned      ADDR_W = 7,
   parameter logic [LEN_W-1:0] SYNC   = SYNC_BYTE
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [LEN_W-1:0]  rx_data,
   input  logic              rx_valid,
   output logic              rx_ready,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [WORD_W-1:0] mem_wdata,
   output logic              cpu_rst,
   output logic              done,
   output logic              err
);

   localparam int unsigned      CNT_W   = 9;
   localparam logic [CNT_W-1:0] MAX_LEN = CNT_W'(2 ** ADDR_W);

   logic [2:0]        state;
   logic [2:0]        nextState;
   logic [CNT_W-1:0]  wordCnt;
   logic [CNT_W-1:0]  cntNext;
   logic [ADDR_W-1:0] addrNext;
   logic [WORD_W-1:0] wdataNext;
   logic [LEN_W-1:0]  chk;
   logic [LEN_W-1:0]  chkNext;
   logic [CNT_W-1:0]  lenExt;
   logic              take;
   logic              isSync;

   // The write cycle is the only bubble in the byte stream.
   assign rx_ready = (state != S_WRITE);
   assign take     = rx_valid & rx_ready;
   assign isSync   = take && (rx_data == SYNC);
   assign lenExt   = CNT_W'(rx_data);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= S_IDLE;
      else     state <= nextState;
   end

   always_comb begin
      nextState = state;
      cntNext   = wordCnt;
      addrNext  = mem_addr;
      wdataNext = mem_wdata;
      chkNext   = chk;
      case (state)
         S_IDLE, S_DONE, S_ERR: begin
            if (isSync) begin
               nextState = S_GETLEN;
               chkNext   = '0;
               addrNext  = '0;
            end
         end
         S_GETLEN: begin
            if (take) begin
               cntNext = lenExt;
               if (lenExt > MAX_LEN)          nextState = S_ERR;
               else if (lenExt == CNT_W'(0))  nextState = S_GETCHK;
               else                           nextState = S_GETHI;
            end
         end
         S_GETHI: begin
            if (take) begin
               wdataNext[15:8] = rx_data;
               chkNext         = chk ^ rx_data;
               nextState       = S_GETLO;
            end
         end
         S_GETLO: begin
            if (take) begin
               wdataNext[7:0] = rx_data;
               chkNext        = chk ^ rx_data;
               nextState      = S_WRITE;
            end
         end
         S_WRITE: begin
            addrNext  = mem_addr + ADDR_W'(1);
            cntNext   = wordCnt - CNT_W'(1);
            nextState = (wordCnt == CNT_W'(1)) ? S_GETCHK : S_GETHI;
         end
         S_GETCHK: begin
            if (take) nextState = (rx_data == chk) ? S_DONE : S_ERR;
         end
         default: nextState = S_IDLE;
      endcase
   end

   // Outputs follow the state being entered so they line up with it exactly.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         wordCnt   <= '0;
         chk       <= '0;
         cpu_rst   <= 1'b1;
         done      <= 1'b0;
         err       <= 1'b0;
      end else begin
         mem_we    <= (nextState == S_WRITE);
         mem_addr  <= addrNext;
         mem_wdata <= wdataNext;
         wordCnt   <= cntNext;
         chk       <= chkNext;
         cpu_rst   <= (nextState != S_DONE);
         done      <= (nextState == S_DONE);
         err       <= (nextState == S_ERR);
      end
   end

endmodule
